// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared widths and sizing for the instruction prefetch buffer.
package instr_prefetch_buffer_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 2;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// Small synchronous FIFO holding fetched instruction words awaiting the IF stage.
module instr_prefetch_buffer_fifo
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  logic [DATA_W-1:0]              i_data,
  output logic [DATA_W-1:0]              o_data,
  output logic [cnt_width(DEPTH)-1:0]    o_count,
  output logic                           o_empty,
  output logic                           o_full
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push is allowed into a full FIFO only when the head leaves the same cycle.
  always_comb begin
    w_do_pop  = i_pop && (r_count != '0);
    w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher between IF and an OBI instruction port.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int unsigned PULP_OBI   = 0,
  parameter int unsigned COREV_PULP = 1,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,          // active-high synchronous reset
  input  logic              req_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              hwlp_jump_i,
  input  logic [ADDR_W-1:0] hwlp_target_i,
  input  logic              fetch_ready_i,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [DATA_W-1:0] instr_rdata_i,
  input  logic              instr_err_i,
  input  logic              instr_err_pmp_i,
  output logic              fetch_valid_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_hold;
  logic              r_hold_stale;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic              w_rsp;
  logic              w_drop;
  logic              w_rsp_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_hold_act;
  logic              w_req_new;
  logic              w_gnt;
  logic              w_stale_gnt;
  logic [OCC_W-1:0]  w_occupancy;
  logic [CNT_W-1:0]  w_out_next;
  logic [CNT_W-1:0]  w_flush_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [DATA_W-1:0] w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_unused_sig;

  // Error flags carry no meaning here; occupancy is tracked via the count.
  assign w_unused_sig = instr_err_i ^ instr_err_pmp_i ^ w_fifo_full;

  // Redirect selection: branch beats hardware-loop jump, target word-aligned.
  always_comb begin
    w_redirect = branch_i || ((COREV_PULP != 0) && hwlp_jump_i);
    w_target   = branch_i ? {branch_addr_i[ADDR_W-1:2], 2'b00}
                          : {hwlp_target_i[ADDR_W-1:2], 2'b00};
  end

  // Response classification and IF-side output path (bypass or FIFO head).
  always_comb begin
    w_rsp         = instr_rvalid_i && (r_outstanding != '0) && !rst_n;
    w_drop        = w_rsp && (r_flush_cnt != '0);
    w_rsp_ok      = w_rsp && (r_flush_cnt == '0) && !w_redirect;
    fetch_valid_o = 1'b0;
    fetch_rdata_o = '0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    if (!rst_n && !w_redirect) begin
      if (w_fifo_empty) begin
        fetch_valid_o = w_rsp_ok;
        fetch_rdata_o = w_rsp_ok ? instr_rdata_i : '0;
        w_push        = w_rsp_ok && !fetch_ready_i;
      end else begin
        fetch_valid_o = 1'b1;
        fetch_rdata_o = w_fifo_head;
        w_pop         = fetch_ready_i;
        w_push        = w_rsp_ok;
      end
    end
  end

  // Request gating: a pending un-granted strict-OBI request is held stable.
  always_comb begin
    w_occupancy  = OCC_W'(r_outstanding) + OCC_W'(w_fifo_count) - OCC_W'(w_pop);
    w_req_new    = req_i && (w_occupancy < OCC_W'(DEPTH));
    w_hold_act   = (PULP_OBI == 0) && r_hold;
    instr_req_o  = !rst_n && (w_hold_act || w_req_new);
    instr_addr_o = w_hold_act ? r_hold_addr : r_addr;
    w_gnt        = instr_req_o && instr_gnt_i;
  end

  // Next outstanding/flush/address; a grant of a stale held request is discarded later.
  always_comb begin
    w_stale_gnt  = w_gnt && w_hold_act && r_hold_stale;
    w_out_next   = r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rsp);
    w_flush_next = w_redirect ? w_out_next
                              : r_flush_cnt - CNT_W'(w_drop) + CNT_W'(w_stale_gnt);
    w_addr_next  = r_addr;
    if (w_redirect)                  w_addr_next = w_target;
    else if (w_gnt && !w_stale_gnt)  w_addr_next = instr_addr_o + ADDR_W'(4);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_addr        <= '0;
      r_hold_addr   <= '0;
      r_outstanding <= '0;
      r_flush_cnt   <= '0;
      r_hold        <= 1'b0;
      r_hold_stale  <= 1'b0;
    end else begin
      r_addr        <= w_addr_next;
      r_outstanding <= w_out_next;
      r_flush_cnt   <= w_flush_next;
      r_hold        <= (PULP_OBI == 0) && instr_req_o && !instr_gnt_i;
      r_hold_addr   <= instr_addr_o;
      r_hold_stale  <= (PULP_OBI == 0) && instr_req_o && !instr_gnt_i &&
                       ((w_hold_act && r_hold_stale) || w_redirect);
    end
  end

  instr_prefetch_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (instr_rdata_i),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign busy_o = (r_outstanding != '0) || (w_fifo_count != '0);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed vector bench for instr_prefetch_buffer (default parameters).
module tb_instr_prefetch_buffer;

  typedef struct {
    logic        rst;
    logic        req;
    logic        br;
    logic [31:0] ba;
    logic        hw;
    logic [31:0] ht;
    logic        rdy;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_valid;
    logic [31:0] e_rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, hwlp_jump_i, fetch_ready_i;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i, instr_err_pmp_i;
  logic [31:0] branch_addr_i, hwlp_target_i, instr_rdata_i;
  logic        fetch_valid_o, instr_req_o, busy_o;
  logic [31:0] fetch_rdata_o, instr_addr_o;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  instr_prefetch_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .branch_i        (branch_i),
    .branch_addr_i   (branch_addr_i),
    .hwlp_jump_i     (hwlp_jump_i),
    .hwlp_target_i   (hwlp_target_i),
    .fetch_ready_i   (fetch_ready_i),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instr_err_i     (instr_err_i),
    .instr_err_pmp_i (instr_err_pmp_i),
    .fetch_valid_o   (fetch_valid_o),
    .fetch_rdata_o   (fetch_rdata_o),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .busy_o          (busy_o)
  );

  function automatic vec_t v(
    input logic rst, input logic req, input logic br, input logic [31:0] ba,
    input logic hw, input logic [31:0] ht, input logic rdy, input logic gnt,
    input logic rv, input logic [31:0] rd, input logic ev, input logic [31:0] erd,
    input logic ereq, input logic [31:0] ea, input logic eb);
    vec_t t;
    t.rst = rst; t.req = req; t.br = br; t.ba = ba; t.hw = hw; t.ht = ht;
    t.rdy = rdy; t.gnt = gnt; t.rv = rv; t.rd = rd;
    t.e_valid = ev; t.e_rdata = erd; t.e_req = ereq; t.e_addr = ea; t.e_busy = eb;
    return t;
  endfunction

  // Drive one cycle's inputs just after a falling edge, check outputs 1ns later.
  task automatic apply(input string name, input vec_t t);
    rst_n = t.rst; req_i = t.req; branch_i = t.br; branch_addr_i = t.ba;
    hwlp_jump_i = t.hw; hwlp_target_i = t.ht; fetch_ready_i = t.rdy;
    instr_gnt_i = t.gnt; instr_rvalid_i = t.rv; instr_rdata_i = t.rd;
    #1;
    n_checks++;
    if (fetch_valid_o !== t.e_valid || fetch_rdata_o !== t.e_rdata ||
        instr_req_o !== t.e_req || instr_addr_o !== t.e_addr || busy_o !== t.e_busy) begin
      n_errors++;
      $display("FAIL %s got valid=%0d rdata=%h req=%0d addr=%h busy=%0d expected valid=%0d rdata=%h req=%0d addr=%h busy=%0d",
               name, fetch_valid_o, fetch_rdata_o, instr_req_o, instr_addr_o, busy_o,
               t.e_valid, t.e_rdata, t.e_req, t.e_addr, t.e_busy);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    hwlp_jump_i = 1'b0; hwlp_target_i = '0; fetch_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    instr_err_i = 1'b0; instr_err_pmp_i = 1'b0;
    repeat (3) @(negedge clk);

    //          rst req br ba          hw ht        rdy gnt rv rd          ev erd        rq addr         bsy
    // reset state, then branch to 0x100 and sequential fetch with zero-latency bypass
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         0, 0, 0, 0,          0, 0,          0, 32'h0,        0));
    tbl.push_back(v(0, 0, 1, 32'h100,    0, 0,         1, 0, 0, 0,          0, 0,          0, 32'h0,        0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 0, 0,          0, 0,          1, 32'h100,      0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 1, 32'hA0,     1, 32'hA0,     1, 32'h104,      1));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 1, 32'hA1,     1, 32'hA1,     1, 32'h108,      1));
    // backpressure: two words buffered, request stalls, then drains in order
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         0, 1, 1, 32'hA2,     1, 32'hA2,     1, 32'h10C,      1));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         0, 1, 1, 32'hA3,     1, 32'hA2,     0, 32'h110,      1));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         0, 1, 0, 0,          1, 32'hA2,     0, 32'h110,      1));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 0, 0,          1, 32'hA2,     1, 32'h110,      1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 1, 32'hA4,     1, 32'hA3,     0, 32'h114,      1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 0, 0,          1, 32'hA4,     0, 32'h114,      1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 0, 0,          0, 0,          0, 32'h114,      0));
    // branch flush: two outstanding, branch to 0x2002, both stale words dropped
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 0, 0,          0, 0,          1, 32'h114,      0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 0, 0,          0, 0,          1, 32'h118,      1));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 0, 0,          0, 0,          0, 32'h11C,      1));
    tbl.push_back(v(0, 1, 1, 32'h2002,   0, 0,         1, 1, 1, 32'hB0,     0, 0,          0, 32'h11C,      1));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 1, 32'hB1,     0, 0,          1, 32'h2000,     1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 1, 32'hC0,     1, 32'hC0,     0, 32'h2004,     1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 0, 0,          0, 0,          0, 32'h2004,     0));
    // OBI hold: 0x40 held ungranted across a branch to 0x80, its data discarded
    tbl.push_back(v(0, 0, 1, 32'h40,     0, 0,         1, 0, 0, 0,          0, 0,          0, 32'h2004,     0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 0, 0, 0,          0, 0,          1, 32'h40,       0));
    tbl.push_back(v(0, 1, 1, 32'h80,     0, 0,         1, 0, 0, 0,          0, 0,          1, 32'h40,       0));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 0, 0,          0, 0,          1, 32'h40,       0));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 1, 0, 0,          0, 0,          1, 32'h40,       0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 1, 32'hD0,     0, 0,          1, 32'h80,       1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 1, 32'hE0,     1, 32'hE0,     0, 32'h84,       1));
    // hwlp jump to 0x303 aligns to 0x300; branch 0x500 beats hwlp 0x600
    tbl.push_back(v(0, 0, 0, 0,          1, 32'h303,   1, 0, 0, 0,          0, 0,          0, 32'h84,       0));
    tbl.push_back(v(0, 0, 1, 32'h500,    1, 32'h600,   1, 0, 0, 0,          0, 0,          0, 32'h300,      0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 0, 0,          0, 0,          1, 32'h500,      0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 1, 32'hF0,     1, 32'hF0,     1, 32'h504,      1));
    // reset mid-stream; late responses after reset are ignored
    tbl.push_back(v(1, 1, 0, 0,          0, 0,         1, 1, 1, 32'hF1,     0, 0,          0, 32'h508,      1));
    tbl.push_back(v(1, 1, 0, 0,          0, 0,         1, 1, 1, 32'hF2,     0, 0,          0, 32'h0,        0));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 1, 32'hF3,     0, 0,          0, 32'h0,        0));
    tbl.push_back(v(0, 0, 1, 32'h700,    0, 0,         1, 0, 0, 0,          0, 0,          0, 32'h0,        0));
    tbl.push_back(v(0, 1, 0, 0,          0, 0,         1, 1, 1, 32'hF4,     0, 0,          1, 32'h700,      0));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 1, 32'hF5,     1, 32'hF5,     0, 32'h704,      1));
    tbl.push_back(v(0, 0, 0, 0,          0, 0,         1, 0, 0, 0,          0, 0,          0, 32'h704,      0));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Hand sequence: address wrap past 0xFFFFFFFC, then redirect clears a non-empty FIFO.
    apply("wrap_branch", v(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 1, 0, 0, 0,        0, 0,        0, 32'h704,       0));
    apply("wrap_req",    v(0, 1, 0, 0,             0, 0, 0, 1, 0, 0,        0, 0,        1, 32'hFFFF_FFFC, 0));
    apply("wrap_next",   v(0, 1, 0, 0,             0, 0, 0, 1, 1, 32'h77,   1, 32'h77,   1, 32'h0,         1));
    apply("flush_fifo",  v(0, 0, 1, 32'h900,       0, 0, 0, 0, 1, 32'h78,   0, 0,        0, 32'h4,         1));
    apply("after_flush", v(0, 0, 0, 0,             0, 0, 1, 0, 0, 0,        0, 0,        0, 32'h900,       0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
- Instruction prefetcher between the IF stage and the OBI-style instruction memory port of a 32-bit RISC-V core.
- Issues word-aligned sequential fetch requests, tracks up to 2 outstanding transactions and buffers responses in a 2-entry FIFO.
- Presents instructions to the fetch stage via a valid/ready handshake; branches and hardware-loop jumps redirect fetching and squash stale data.

Parameters:
- PULP_OBI, 0, 0 = strict OBI: address and request held stable until granted; 1 = legacy mode, a pending request may be retargeted.
- COREV_PULP, 1, 1 = hwlp_jump_i honoured; 0 = hwlp_jump_i ignored.
- DEPTH, 2, FIFO depth and maximum outstanding transactions (outstanding + FIFO entries <= DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-high (reset when 1).
- req_i  in  1  fetching enabled.
- branch_i  in  1  redirect to branch_addr_i.
- branch_addr_i  in  32  branch target.
- hwlp_jump_i  in  1  hardware-loop redirect.
- hwlp_target_i  in  32  hardware-loop target.
- fetch_ready_i  in  1  IF stage accepts instruction.
- instr_gnt_i  in  1  memory grant.
- instr_rvalid_i  in  1  memory response valid.
- instr_rdata_i  in  32  response data.
- instr_err_i  in  1  bus error (not used by this block).
- instr_err_pmp_i  in  1  PMP error (not used by this block).
- fetch_valid_o  out  1  instruction valid to IF.
- fetch_rdata_o  out  32  instruction word to IF.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  request address, bits [1:0] always 0.
- busy_o  out  1  transactions outstanding or FIFO non-empty.

Behaviour:
- Reset: all outputs 0; fetch address 0; FIFO empty; outstanding = 0; flush count = 0.
- Redirect: branch_i has priority over hwlp_jump_i.
  - New fetch address = target with [1:0] cleared.
  - FIFO cleared the same edge.
  - Every transaction outstanding at the redirect is marked for discard (flush count = outstanding).
  - Redirects are accepted with or without req_i.
- Request: instr_req_o = req_i && (outstanding + fifo_count < DEPTH), with entries popped this cycle counted as free.
  - instr_addr_o = current fetch address.
  - On instr_req_o && instr_gnt_i: outstanding+1 and fetch address += 4, wrapping modulo 2^32.
- OBI stability (PULP_OBI=0): once instr_req_o rises without a grant, instr_req_o and instr_addr_o hold until granted, even across a redirect.
  - A request granted after a redirect is added to the flush count.
  - The target address is requested next.
  - PULP_OBI=1: a redirect retargets the pending address immediately.
- Response (instr_rvalid_i): outstanding-1.
  - If flush count > 0, the data is dropped and flush count-1.
  - Otherwise the data goes to the IF stage or the FIFO.
  - Simultaneous grant and rvalid leave outstanding unchanged.
- Output path:
  - FIFO empty: fetch_valid_o = valid non-flushed instr_rvalid_i, fetch_rdata_o = instr_rdata_i (zero-latency bypass). If fetch_ready_i = 0, the word is pushed into the FIFO.
  - FIFO non-empty: fetch_valid_o = 1, fetch_rdata_o = FIFO head, popped when fetch_ready_i = 1. An arriving response is pushed behind, preserving order.
  - In a cycle with branch_i or hwlp_jump_i asserted, fetch_valid_o = 0 and that cycle's response is discarded.
  - fetch_rdata_o = 0 when fetch_valid_o = 0.
- FIFO full: no overflow is possible, because request gating guarantees a slot for every non-flushed response.
- Error inputs: ignored; data forwarded unchanged.
- req_i = 0: no new requests; in-flight responses are still accepted and buffered.
- busy_o = (outstanding != 0) || (fifo_count != 0).
- Reset asserted mid-operation: all state cleared next edge; responses arriving after reset are dropped.

Decomposition:
- Shared package: ADDR_W = 32, DATA_W = 32, default DEPTH, and the counter width $clog2(DEPTH+1).
- One natural sub-module, prefetch_fifo:
  - synchronous FIFO with push/pop/flush, count, empty/full and head data outputs;
  - the top level holds the address/outstanding/flush control.

Test Plan:
- Sequential fetch: reset, branch_i with branch_addr_i = 0x100, req_i = 1, gnt and rvalid every cycle, fetch_ready_i = 1 -> addresses 0x100, 0x104, 0x108; fetch_rdata_o equals each response one-to-one, zero latency.
- Backpressure: fetch_ready_i = 0 while 2 responses arrive -> FIFO holds 2 and instr_req_o = 0. When fetch_ready_i = 1, data pops in order and requests resume.
- Branch flush: 2 outstanding, then branch_i with 0x2002 -> next address 0x2000; both stale responses dropped (fetch_valid_o stays 0); the first valid word is the 0x2000 response.
- OBI hold: req at 0x40 with gnt = 0 for 3 cycles, branch to 0x80 meanwhile -> instr_addr_o stays 0x40 until granted. The 0x40 data is discarded, then 0x80 is requested.
- hwlp jump: hwlp_jump_i with target 0x300 -> fetch address 0x300. Simultaneous branch_i to 0x500 and hwlp_jump_i -> 0x500 wins.
- Reset and busy: mid-stream, reset asserted -> next cycle all outputs 0 and busy_o = 0. After release, no fetch_valid_o until a new branch-issued request is granted and returned.
